// File: rtl/btb_update_ctrl.sv
// ---------------------------------------------------------------------------
// btb_update_ctrl
//
// Write sequencer for the branch target buffer. The buffer has a single
// lookup port (btb_pc). Fetch normally drives it. Resolved branches from EX
// are queued here, and each one takes the port twice:
//   1. PROBE: check whether the branch PC is already present.
//   2. WRITE: insert or overwrite it.
// Fetch has priority on the port. An update that has been blocked for
// STARVE_LIMIT consecutive cycles takes the port for one cycle and stalls
// fetch. A pipeline flush clears the buffer and drops any queued updates.
//
// Ports
//   clk, reset              clock; asynchronous active-low reset
//   fetch_req/fetch_pc      IF lookup request and PC
//   fetch_hit/fetch_target  lookup result (combinational); target is 0 on miss
//   fetch_stall             port taken by an update this cycle; IF holds its PC
//   upd_valid/upd_ready     EX resolved-branch handshake
//   upd_pc/target/taken     resolved-branch payload
//   flush_req               clear buffer and queue
//   btb_pc                  PC presented to the buffer (lookup and write)
//   btb_target/btb_way      write data and way, valid while btb_insert is high
//   btb_insert, btb_clr     one-cycle write and clear strobes
//   btb_found/btb_hit_way   buffer lookup result for btb_pc
//   btb_lookup_target       target held in the hitting way
//   busy                    controller active or updates pending
// ---------------------------------------------------------------------------
module btb_update_ctrl #(
   parameter int BTB_SIZE     = 8,   // power of 2
   parameter int WAY_W        = 3,   // log2(BTB_SIZE)
   parameter int QDEPTH       = 2,   // power of 2, at least 2
   parameter int STARVE_LIMIT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             fetch_req,
   input  logic [31:0]      fetch_pc,
   output logic             fetch_hit,
   output logic [31:0]      fetch_target,
   output logic             fetch_stall,
   input  logic             upd_valid,
   output logic             upd_ready,
   input  logic [31:0]      upd_pc,
   input  logic [31:0]      upd_target,
   input  logic             upd_taken,
   input  logic             flush_req,
   output logic [31:0]      btb_pc,
   output logic [31:0]      btb_target,
   output logic             btb_insert,
   output logic [WAY_W-1:0] btb_way,
   output logic             btb_clr,
   input  logic             btb_found,
   input  logic [WAY_W-1:0] btb_hit_way,
   input  logic [31:0]      btb_lookup_target,
   output logic             busy
);

   localparam int QPW = $clog2(QDEPTH);
   localparam int SCW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {IDLE, PROBE, WRITE, CLEAR} state_t;

   state_t           state, state_nxt;
   logic [WAY_W-1:0] rr_ptr, rr_nxt;
   logic [WAY_W-1:0] way_q, way_nxt;
   logic [SCW-1:0]   starve_cnt, starve_nxt;

   // ---------------- update queue ----------------
   // Pointers carry one extra wrap bit, so full and empty can be told apart.
   logic [31:0]    q_pc  [QDEPTH];
   logic [31:0]    q_tgt [QDEPTH];
   logic           q_tk  [QDEPTH];
   logic [QPW:0]   wr_ptr, rd_ptr;
   logic [QPW-1:0] wr_idx, rd_idx;
   logic           empty, full, enq, pop, q_clr;
   logic [31:0]    h_pc, h_tgt;
   logic           h_tk;

   assign wr_idx = wr_ptr[QPW-1:0];
   assign rd_idx = rd_ptr[QPW-1:0];
   assign empty  = (wr_ptr == rd_ptr);
   assign full   = (wr_ptr[QPW] != rd_ptr[QPW]) && (wr_idx == rd_idx);
   assign h_pc   = q_pc[rd_idx];
   assign h_tgt  = q_tgt[rd_idx];
   assign h_tk   = q_tk[rd_idx];

   assign upd_ready = reset & ~full & ~flush_req;
   assign enq       = upd_valid & upd_ready;

   // Payload storage. Entries are only read after their write pointer has
   // been advanced, so the storage needs no reset.
   always_ff @(posedge clk) begin
      if (enq) begin
         q_pc[wr_idx]  <= upd_pc;
         q_tgt[wr_idx] <= upd_target;
         q_tk[wr_idx]  <= upd_taken;
      end
   end

   // ---------------- port arbitration ----------------
   logic needs_port, starved, owns;

   assign needs_port = (state == PROBE) || (state == WRITE);
   assign starved    = (starve_cnt == SCW'(STARVE_LIMIT));
   assign owns       = needs_port && (!fetch_req || starved);

   // ---------------- next state ----------------
   logic insert, clr;

   always_comb begin
      state_nxt  = state;
      rr_nxt     = rr_ptr;
      way_nxt    = way_q;
      starve_nxt = starve_cnt;
      pop        = 1'b0;
      q_clr      = 1'b0;
      insert     = 1'b0;
      clr        = 1'b0;
      case (state)
         // Also start on an update being accepted this cycle. This lets the
         // probe run in the cycle right after acceptance.
         IDLE: if (!empty || enq) state_nxt = PROBE;
         PROBE: begin
            if (!flush_req) begin
               if (owns) begin
                  starve_nxt = '0;
                  if (!h_tk || (btb_found && btb_lookup_target == h_tgt)) begin
                     // Not taken, or already correct: nothing to write.
                     pop       = 1'b1;
                     state_nxt = IDLE;
                  end else if (btb_found) begin
                     way_nxt   = btb_hit_way;
                     state_nxt = WRITE;
                  end else begin
                     way_nxt   = rr_ptr;
                     rr_nxt    = (rr_ptr == WAY_W'(BTB_SIZE - 1)) ? '0 : rr_ptr + WAY_W'(1);
                     state_nxt = WRITE;
                  end
               end else if (!starved) begin
                  starve_nxt = starve_cnt + SCW'(1);
               end
            end
         end
         WRITE: begin
            if (!flush_req) begin
               if (owns) begin
                  starve_nxt = '0;
                  insert     = 1'b1;
                  pop        = 1'b1;
                  state_nxt  = IDLE;
               end else if (!starved) begin
                  starve_nxt = starve_cnt + SCW'(1);
               end
            end
         end
         CLEAR: begin
            clr        = 1'b1;
            q_clr      = 1'b1;
            rr_nxt     = '0;
            starve_nxt = '0;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // Flush wins from every state. It aborts an in-flight probe or write.
      if (flush_req) state_nxt = CLEAR;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         way_q      <= '0;
         starve_cnt <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
      end else begin
         state      <= state_nxt;
         rr_ptr     <= rr_nxt;
         way_q      <= way_nxt;
         starve_cnt <= starve_nxt;
         // A clear drops everything queued before it. An update accepted in
         // the same cycle is still kept.
         if (q_clr)    rd_ptr <= wr_ptr;
         else if (pop) rd_ptr <= rd_ptr + (QPW+1)'(1);
         if (enq)      wr_ptr <= wr_ptr + (QPW+1)'(1);
      end
   end

   // ---------------- outputs ----------------
   assign fetch_stall  = fetch_req & owns;
   assign fetch_hit    = reset & fetch_req & btb_found & ~fetch_stall;
   assign fetch_target = fetch_hit ? btb_lookup_target : 32'h0;

   assign btb_pc     = !reset ? 32'h0 : (owns ? h_pc : fetch_pc);
   assign btb_insert = insert;
   assign btb_target = insert ? h_tgt : 32'h0;
   assign btb_way    = insert ? way_q : '0;
   assign btb_clr    = clr;
   assign busy       = (state != IDLE) || !empty;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// ---------------------------------------------------------------------------
// Bench for btb_update_ctrl. A small behavioural buffer answers lookups on
// btb_pc and applies insert/clear strobes. Directed tasks cover latency,
// overwrite, round-robin wrap, starvation, flush and reset. The random task
// checks every insert against a reference model of buffer contents.
// ---------------------------------------------------------------------------
module tb_btb_update_ctrl;
   localparam int NWAY = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        fetch_req, fetch_hit, fetch_stall;
   logic [31:0] fetch_pc, fetch_target;
   logic        upd_valid, upd_ready, upd_taken, flush_req;
   logic [31:0] upd_pc, upd_target;
   logic [31:0] btb_pc, btb_target, btb_lookup_target;
   logic        btb_insert, btb_clr, btb_found, busy;
   logic [2:0]  btb_way, btb_hit_way;

   int checks = 0;
   int errors = 0;

   btb_update_ctrl #(.BTB_SIZE(8), .WAY_W(3), .QDEPTH(2), .STARVE_LIMIT(4)) dut (
      .clk(clk), .reset(reset),
      .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_hit(fetch_hit),
      .fetch_target(fetch_target), .fetch_stall(fetch_stall),
      .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
      .upd_target(upd_target), .upd_taken(upd_taken), .flush_req(flush_req),
      .btb_pc(btb_pc), .btb_target(btb_target), .btb_insert(btb_insert),
      .btb_way(btb_way), .btb_clr(btb_clr), .btb_found(btb_found),
      .btb_hit_way(btb_hit_way), .btb_lookup_target(btb_lookup_target), .busy(busy));

   always #5 clk = ~clk;

   // ---------------- behavioural buffer storage ----------------
   logic        env_wipe;
   logic        env_v  [NWAY];
   logic [31:0] env_pc [NWAY];
   logic [31:0] env_t  [NWAY];

   always @(posedge clk) begin
      if (env_wipe || btb_clr) begin
         for (int i = 0; i < NWAY; i++) env_v[i] <= 1'b0;
      end else if (btb_insert) begin
         env_v[btb_way]  <= 1'b1;
         env_pc[btb_way] <= btb_pc;
         env_t[btb_way]  <= btb_target;
      end
   end

   always_comb begin
      btb_found = 1'b0;
      btb_hit_way = 3'd0;
      btb_lookup_target = 32'h0;
      for (int i = 0; i < NWAY; i++)
         if (!btb_found && env_v[i] && env_pc[i] == btb_pc) begin
            btb_found = 1'b1;
            btb_hit_way = 3'(i);
            btb_lookup_target = env_t[i];
         end
   end

   function automatic void env_lookup(input logic [31:0] pc, output logic f, output logic [31:0] t);
      f = 1'b0;
      t = 32'h0;
      for (int i = 0; i < NWAY; i++)
         if (!f && env_v[i] && env_pc[i] == pc) begin f = 1'b1; t = env_t[i]; end
   endfunction

   // ---------------- reference model ----------------
   // Buffer contents after every accepted update is applied in order, plus
   // the list of writes those updates must produce.
   typedef struct packed {logic [2:0] way; logic [31:0] pc; logic [31:0] tgt;} ins_t;
   ins_t        expq[$];
   logic        m_v  [NWAY];
   logic [31:0] m_pc [NWAY];
   logic [31:0] m_t  [NWAY];
   int          m_rr;

   task automatic model_accept(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
      int   hit;
      ins_t e;
      hit = -1;
      if (!tk) return;
      for (int i = 0; i < NWAY; i++) if (m_v[i] && m_pc[i] == pc) hit = i;
      if (hit >= 0) begin
         if (m_t[hit] != tgt) begin
            m_t[hit] = tgt;
            e.way = 3'(hit); e.pc = pc; e.tgt = tgt; expq.push_back(e);
         end
      end else begin
         m_v[m_rr] = 1'b1; m_pc[m_rr] = pc; m_t[m_rr] = tgt;
         e.way = 3'(m_rr); e.pc = pc; e.tgt = tgt; expq.push_back(e);
         m_rr = (m_rr + 1) % NWAY;
      end
   endtask

   // ---------------- stimulus helpers (no checking of DUT values) ----------------
   task automatic send_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
      int n;
      @(negedge clk);
      upd_valid = 1'b1; upd_pc = pc; upd_target = tgt; upd_taken = tk;
      #1;
      n = 0;
      while (!upd_ready && n < 20) begin @(negedge clk); #1; n++; end
      if (!upd_ready) begin checks++; errors++; $display("FAIL send_upd_timeout: upd_ready=%0b required 1", upd_ready); end
      @(negedge clk);
      upd_valid = 1'b0;
   endtask

   task automatic watch_insert(input int max, output bit seen, output int lat,
                               output logic [2:0] way, output logic [31:0] pc, output logic [31:0] tgt);
      seen = 0; lat = 0; way = 3'd0; pc = 32'h0; tgt = 32'h0;
      for (int k = 0; k <= max; k++) begin
         #1;
         if (btb_insert) begin seen = 1; lat = k; way = btb_way; pc = btb_pc; tgt = btb_target; break; end
         @(negedge clk);
      end
   endtask

   task automatic do_flush();
      @(negedge clk); flush_req = 1'b1;
      @(negedge clk); flush_req = 1'b0;
      @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      fetch_req = 1'b1; fetch_pc = 32'h1234; upd_valid = 1'b1; upd_pc = 32'h55;
      upd_target = 32'h66; upd_taken = 1'b1; flush_req = 1'b0; env_wipe = 1'b1;
      #1 reset = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (upd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b exp 0", upd_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b exp 0", busy); end
      checks++; if (btb_pc !== 32'h0) begin errors++; $display("FAIL reset_btb_pc: got %h exp 0", btb_pc); end
      checks++; if ({btb_insert, btb_clr, fetch_stall, fetch_hit} !== 4'b0) begin errors++; $display("FAIL reset_strobes: got %b exp 0000", {btb_insert, btb_clr, fetch_stall, fetch_hit}); end
      @(negedge clk);
      reset = 1'b1; env_wipe = 1'b0; fetch_req = 1'b0; upd_valid = 1'b0;
      #1;
      checks++; if (upd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_release: ready=%0b busy=%0b exp 1/0", upd_ready, busy); end
   endtask

   task automatic test_basic();
      @(negedge clk);
      upd_valid = 1'b1; upd_pc = 32'h100; upd_target = 32'h200; upd_taken = 1'b1;
      #1;
      checks++; if (upd_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %0b exp 1", upd_ready); end
      @(negedge clk); upd_valid = 1'b0; #1;
      checks++; if (busy !== 1'b1 || btb_insert !== 1'b0 || btb_pc !== 32'h100) begin errors++; $display("FAIL basic_probe: busy=%0b ins=%0b pc=%h exp 1/0/100", busy, btb_insert, btb_pc); end
      @(negedge clk); #1;
      checks++; if (btb_insert !== 1'b1) begin errors++; $display("FAIL basic_insert: got %0b exp 1", btb_insert); end
      checks++; if (btb_way !== 3'd0 || btb_target !== 32'h200) begin errors++; $display("FAIL basic_wdata: way=%0d tgt=%h exp 0/200", btb_way, btb_target); end
      @(negedge clk); fetch_req = 1'b1; fetch_pc = 32'h100; #1;
      checks++; if (btb_insert !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_done: ins=%0b busy=%0b exp 0/0", btb_insert, busy); end
      checks++; if (fetch_hit !== 1'b1 || fetch_target !== 32'h200) begin errors++; $display("FAIL basic_fetch: hit=%0b tgt=%h exp 1/200", fetch_hit, fetch_target); end
      fetch_req = 1'b0;
   endtask

   task automatic test_overwrite();
      bit s; int lat; logic [2:0] w; logic [31:0] p, t;
      send_upd(32'h100, 32'h300, 1'b1);
      watch_insert(10, s, lat, w, p, t);
      checks++; if (!s || lat != 1) begin errors++; $display("FAIL ovw_insert: seen=%0b lat=%0d exp 1/1", s, lat); end
      checks++; if (w !== 3'd0 || t !== 32'h300 || p !== 32'h100) begin errors++; $display("FAIL ovw_wdata: way=%0d pc=%h tgt=%h exp 0/100/300", w, p, t); end
      send_upd(32'h100, 32'h300, 1'b1);
      watch_insert(5, s, lat, w, p, t);
      checks++; if (s) begin errors++; $display("FAIL ovw_same: insert seen=1 exp 0"); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovw_same_busy: got %0b exp 0", busy); end
      send_upd(32'h180, 32'h400, 1'b1);
      watch_insert(10, s, lat, w, p, t);
      checks++; if (!s || w !== 3'd1) begin errors++; $display("FAIL ovw_rr_kept: seen=%0b way=%0d exp 1/1", s, w); end
   endtask

   task automatic test_starve();
      bit exp_st;
      @(negedge clk);
      fetch_req = 1'b1; fetch_pc = 32'h100;
      upd_valid = 1'b1; upd_pc = 32'h180; upd_target = 32'h999; upd_taken = 1'b0;
      #1;
      checks++; if (upd_ready !== 1'b1 || fetch_stall !== 1'b0) begin errors++; $display("FAIL starve_accept: ready=%0b stall=%0b exp 1/0", upd_ready, fetch_stall); end
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         upd_valid = 1'b0;
         #1;
         exp_st = (k == 4);
         checks++; if (fetch_stall !== exp_st) begin errors++; $display("FAIL starve_stall_%0d: got %0b exp %0b", k, fetch_stall, exp_st); end
         checks++; if (fetch_hit !== !exp_st || fetch_target !== (exp_st ? 32'h0 : 32'h300)) begin errors++; $display("FAIL starve_hit_%0d: hit=%0b tgt=%h exp %0b", k, fetch_hit, fetch_target, !exp_st); end
         if (k == 4) begin checks++; if (btb_pc !== 32'h180) begin errors++; $display("FAIL starve_btb_pc: got %h exp 180", btb_pc); end end
         if (k == 5) begin checks++; if (busy !== 1'b0) begin errors++; $display("FAIL starve_done: busy=%0b exp 0", busy); end end
      end
      fetch_req = 1'b0;
   endtask

   task automatic test_wrap();
      bit s; int lat; logic [2:0] w; logic [31:0] p, t;
      @(negedge clk); flush_req = 1'b1; #1;
      checks++; if (upd_ready !== 1'b0) begin errors++; $display("FAIL wrap_flush_ready: got %0b exp 0", upd_ready); end
      @(negedge clk); flush_req = 1'b0; #1;
      checks++; if (btb_clr !== 1'b1) begin errors++; $display("FAIL wrap_clr: got %0b exp 1", btb_clr); end
      @(negedge clk); #1;
      checks++; if (btb_clr !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL wrap_clr_done: clr=%0b busy=%0b exp 0/0", btb_clr, busy); end
      for (int i = 0; i < 9; i++) begin
         send_upd(32'h1000 + 32'(i) * 32'd4, 32'h8000 + 32'(i), 1'b1);
         watch_insert(10, s, lat, w, p, t);
         checks++; if (!s || lat != 1 || w !== 3'(i % NWAY) || p !== 32'h1000 + 32'(i) * 32'd4 || t !== 32'h8000 + 32'(i)) begin
            errors++; $display("FAIL wrap_way_%0d: seen=%0b lat=%0d way=%0d pc=%h tgt=%h exp way %0d", i, s, lat, w, p, t, i % NWAY); end
      end
      @(negedge clk);
      upd_valid = 1'b1; upd_pc = 32'h2000; upd_target = 32'h2100; upd_taken = 1'b0;
      @(negedge clk); upd_valid = 1'b0; #1;
      checks++; if (busy !== 1'b1 || btb_insert !== 1'b0) begin errors++; $display("FAIL wrap_nt_probe: busy=%0b ins=%0b exp 1/0", busy, btb_insert); end
      @(negedge clk); #1;
      checks++; if (busy !== 1'b0 || btb_insert !== 1'b0) begin errors++; $display("FAIL wrap_nt_done: busy=%0b ins=%0b exp 0/0", busy, btb_insert); end
   endtask

   task automatic test_flush();
      @(negedge clk);
      fetch_req = 1'b1; fetch_pc = 32'h5555;
      upd_valid = 1'b1; upd_pc = 32'h3000; upd_target = 32'h3100; upd_taken = 1'b1;
      #1;
      checks++; if (upd_ready !== 1'b1) begin errors++; $display("FAIL flush_acc1: got %0b exp 1", upd_ready); end
      @(negedge clk); upd_pc = 32'h3004; #1;
      checks++; if (upd_ready !== 1'b1) begin errors++; $display("FAIL flush_acc2: got %0b exp 1", upd_ready); end
      @(negedge clk); upd_valid = 1'b0; #1;
      checks++; if (upd_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL flush_full: ready=%0b busy=%0b exp 0/1", upd_ready, busy); end
      @(negedge clk); fetch_req = 1'b0; #1;
      checks++; if (btb_pc !== 32'h3000) begin errors++; $display("FAIL flush_probe_pc: got %h exp 3000", btb_pc); end
      @(negedge clk); flush_req = 1'b1; upd_valid = 1'b1; upd_pc = 32'h3008; #1;
      checks++; if (btb_insert !== 1'b0 || upd_ready !== 1'b0) begin errors++; $display("FAIL flush_abort: ins=%0b ready=%0b exp 0/0", btb_insert, upd_ready); end
      @(negedge clk); flush_req = 1'b0; upd_valid = 1'b0; #1;
      checks++; if (btb_clr !== 1'b1 || btb_insert !== 1'b0) begin errors++; $display("FAIL flush_clr: clr=%0b ins=%0b exp 1/0", btb_clr, btb_insert); end
      @(negedge clk); #1;
      checks++; if (busy !== 1'b0 || btb_clr !== 1'b0 || upd_ready !== 1'b1) begin errors++; $display("FAIL flush_done: busy=%0b clr=%0b ready=%0b exp 0/0/1", busy, btb_clr, upd_ready); end
   endtask

   task automatic rand_cycle(input bit drive);
      logic f; logic [31:0] t; bit eh; ins_t e;
      @(negedge clk);
      if (drive) begin
         fetch_req  = 1'($urandom_range(0, 1));
         fetch_pc   = 32'h4000 + 32'($urandom_range(0, 13)) * 32'd4;
         upd_valid  = ($urandom_range(0, 9) < 4);
         upd_pc     = 32'h4000 + 32'($urandom_range(0, 11)) * 32'd4;
         upd_target = 32'h9000 + 32'($urandom_range(0, 2)) * 32'd16;
         upd_taken  = ($urandom_range(0, 3) != 0);
      end else begin
         fetch_req = 1'b0; upd_valid = 1'b0;
      end
      #1;
      env_lookup(fetch_pc, f, t);
      eh = fetch_req && !fetch_stall && f;
      checks++; if (fetch_hit !== eh || fetch_target !== (eh ? t : 32'h0)) begin errors++; $display("FAIL rand_fetch: hit=%0b tgt=%h exp %0b/%h", fetch_hit, fetch_target, eh, eh ? t : 32'h0); end
      checks++; if (fetch_stall && !fetch_req) begin errors++; $display("FAIL rand_stall: stall=1 with fetch_req=0 exp 0"); end
      if (btb_insert) begin
         checks++;
         if (expq.size() == 0) begin errors++; $display("FAIL rand_insert_unexpected: way=%0d pc=%h", btb_way, btb_pc); end
         else begin
            e = expq.pop_front();
            if (btb_way !== e.way || btb_pc !== e.pc || btb_target !== e.tgt) begin
               errors++; $display("FAIL rand_insert: way=%0d pc=%h tgt=%h exp %0d/%h/%h", btb_way, btb_pc, btb_target, e.way, e.pc, e.tgt); end
         end
      end
      if (upd_valid && upd_ready) model_accept(upd_pc, upd_target, upd_taken);
   endtask

   task automatic test_random();
      int n;
      do_flush();
      expq.delete();
      m_rr = 0;
      for (int i = 0; i < NWAY; i++) begin m_v[i] = 1'b0; m_pc[i] = 32'h0; m_t[i] = 32'h0; end
      for (int c = 0; c < 400; c++) rand_cycle(1'b1);
      n = 0;
      rand_cycle(1'b0);
      while (busy && n < 40) begin rand_cycle(1'b0); n++; end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand_drain: busy=%0b exp 0", busy); end
      checks++; if (expq.size() != 0) begin errors++; $display("FAIL rand_missing_inserts: %0d left exp 0", expq.size()); end
      for (int i = 0; i < NWAY; i++) begin
         checks++;
         if (env_v[i] !== m_v[i] || (m_v[i] && (env_pc[i] !== m_pc[i] || env_t[i] !== m_t[i]))) begin
            errors++; $display("FAIL rand_contents_%0d: v=%0b pc=%h tgt=%h exp %0b/%h/%h", i, env_v[i], env_pc[i], env_t[i], m_v[i], m_pc[i], m_t[i]); end
      end
   endtask

   task automatic test_reset_mid();
      logic f; logic [31:0] t;
      fetch_pc = 32'h7777; fetch_req = 1'b0;
      send_upd(32'h6000, 32'h6100, 1'b1);
      @(negedge clk); #1;
      checks++; if (btb_insert !== 1'b1) begin errors++; $display("FAIL rmid_in_write: ins=%0b exp 1", btb_insert); end
      reset = 1'b0; #1;
      checks++; if (btb_insert !== 1'b0 || busy !== 1'b0 || upd_ready !== 1'b0) begin errors++; $display("FAIL rmid_async: ins=%0b busy=%0b ready=%0b exp 0/0/0", btb_insert, busy, upd_ready); end
      checks++; if (btb_pc !== 32'h0 || btb_target !== 32'h0 || btb_way !== 3'd0 || btb_clr !== 1'b0) begin errors++; $display("FAIL rmid_outs: pc=%h tgt=%h way=%0d clr=%0b exp 0", btb_pc, btb_target, btb_way, btb_clr); end
      @(negedge clk); reset = 1'b1; #1;
      checks++; if (busy !== 1'b0 || upd_ready !== 1'b1 || btb_insert !== 1'b0) begin errors++; $display("FAIL rmid_release: busy=%0b ready=%0b ins=%0b exp 0/1/0", busy, upd_ready, btb_insert); end
      env_lookup(32'h6000, f, t);
      checks++; if (f !== 1'b0) begin errors++; $display("FAIL rmid_no_write: entry found=%0b exp 0", f); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_overwrite();
      test_starve();
      test_wrap();
      test_flush();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/btb_update_ctrl.md
Name: btb_update_ctrl

Overview:
- Sequences all writes into the branch target buffer and shares its single `pc` port between fetch-stage lookups and execute-stage branch-resolution updates.
- Buffers resolved branches in a small queue. Probes the buffer for each one, then inserts or overwrites an entry, choosing a victim way round-robin.
- Also sequences buffer clear on pipeline flush.
- Sits between the EX-stage branch unit, the IF-stage PC logic and the buffer storage.

Parameters:
- BTB_SIZE, 8, number of buffer entries; must be a power of 2.
- WAY_W, 3, width of way index; equals log2(BTB_SIZE).
- QDEPTH, 2, depth of update queue; must be a power of 2.
- STARVE_LIMIT, 4, consecutive blocked cycles before an update steals the port.

Ports:
- clk  in  1  Single clock; all state on its rising edge.
- reset  in  1  Asynchronous, active-low reset.
- fetch_req  in  1  IF-stage lookup request this cycle.
- fetch_pc  in  32  PC to look up.
- fetch_hit  out  1  Lookup hit (combinational).
- fetch_target  out  32  Predicted target; 0 when not hit.
- fetch_stall  out  1  Port stolen this cycle; IF must hold fetch_pc.
- upd_valid  in  1  Resolved-branch update offered.
- upd_ready  out  1  Controller accepts update.
- upd_pc  in  32  Branch PC.
- upd_target  in  32  Resolved target.
- upd_taken  in  1  Branch was taken.
- flush_req  in  1  Clear buffer and queue.
- btb_pc  out  32  PC driven to buffer.
- btb_target  out  32  Write target to buffer.
- btb_insert  out  1  One-cycle write strobe.
- btb_way  out  WAY_W  Way written on insert.
- btb_clr  out  1  One-cycle clear strobe to buffer.
- btb_found  in  1  Buffer hit for btb_pc.
- btb_hit_way  in  WAY_W  Way that hit.
- btb_lookup_target  in  32  Target stored in the hitting way.
- busy  out  1  State != IDLE or queue non-empty.

Behaviour:
- Reset (reset=0, asynchronous):
  - State=IDLE, queue empty, rr_ptr=0, starve_cnt=0.
  - All strobes 0; btb_pc, btb_target and btb_way are 0.
  - upd_ready=0 while reset is asserted.
- Port mux (combinational):
  - Update owns the port when state is PROBE or WRITE and either fetch_req=0 or starve_cnt==STARVE_LIMIT. btb_pc = queue-head pc.
  - Otherwise btb_pc = fetch_pc.
  - fetch_hit = fetch_req & btb_found & !fetch_stall.
  - fetch_target = btb_lookup_target when fetch_hit, else 0.
  - fetch_stall = fetch_req & update owns port.
- Queue:
  - upd_ready = !full & !flush_req.
  - Enqueue on upd_valid & upd_ready. Each entry holds {pc, target, taken}.
  - A simultaneous enqueue and pop are both honoured.
- FSM:
  - IDLE:
    - flush_req -> CLEAR.
    - Else if queue non-empty -> PROBE.
  - PROBE (needs port):
    - If the port is denied, stay and increment starve_cnt.
    - If the port is granted, clear starve_cnt and sample btb_found, btb_hit_way and btb_lookup_target:
      - taken=0: pop -> IDLE. No removal.
      - taken=1, hit, target equal: pop -> IDLE.
      - taken=1, hit, target differs: latch way=btb_hit_way -> WRITE.
      - taken=1, miss: latch way=rr_ptr, set rr_ptr=rr_ptr+1 (wrap mod BTB_SIZE) -> WRITE.
  - WRITE (needs port):
    - Stall and starve rules are the same as PROBE.
    - When granted: btb_insert=1 for exactly one cycle, btb_way=latched way, btb_target=head target; pop -> IDLE.
  - CLEAR:
    - btb_clr=1 for one cycle.
    - Queue emptied, rr_ptr=0, starve_cnt=0 -> IDLE.
- Flush priority: flush_req in any state forces the next state to CLEAR.
  - An in-progress PROBE or WRITE is aborted with no insert.
  - An update offered in the same cycle as flush_req is not accepted.
- Latency with fetch idle:
  - Accept at edge t; PROBE at t+1; WRITE at t+2.
  - Insert on the edge ending t+2; the entry is visible to lookup from t+3.
- The starve counter saturates at STARVE_LIMIT and is cleared whenever the port is granted to the update.
- The queue-full and empty boundaries use one extra pointer bit. No overflow is possible because upd_ready gates acceptance.

Test Plan:
- Reset, then taken update pc=0x100/tgt=0x200 with fetch_req=0 -> upd_ready=1; btb_insert pulses one cycle later in WRITE with btb_way=0, btb_target=0x200. A fetch of 0x100 at t+3 gives fetch_hit=1, fetch_target=0x200.
- Same pc=0x100 with tgt=0x300, btb_hit_way=0 -> insert to way 0 (overwrite) and rr_ptr unchanged. Repeat the update with tgt=0x300 -> no insert.
- Nine distinct taken misses -> ways 0..7 then 0 (wrap). A not-taken update -> no insert, popped in one PROBE cycle.
- fetch_req held high with a pending update -> fetch_stall=0 for 4 cycles, then fetch_stall=1 for exactly one cycle while the update probes. fetch_hit=0 on that cycle.
- Fill the queue (2 entries) -> upd_ready=0. Assert flush_req during WRITE -> no btb_insert, btb_clr pulses one cycle, queue empty, busy=0 the next cycle.
- Drop reset to 0 mid-WRITE -> btb_insert drops asynchronously, all outputs read 0 and state is IDLE after release.
